// File: rtl/rtc_calendar_counter.sv
`default_nettype none
// ============================================================================
// Module      : rtc_calendar_counter
// Description : Free-running BCD real-time clock/calendar. Captures the
//               date/time/weekday fields from set_time on a load strobe
//               (after validation) and advances once per second with full
//               Gregorian carry: month lengths, leap years, weekday roll.
// Ports       : clk, rst (async, active-high), run_en (prescaler enable),
//               load + set_year/month/day/hour/minute/sec/week (BCD load),
//               year/month/day/hour/minute/sec/week (current BCD time),
//               sec_tick (1-cycle pulse with each new second),
//               load_err (1-cycle pulse when a load is rejected).
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_calendar_counter #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_en,
    input  logic        load,
    input  logic [15:0] set_year,
    input  logic [7:0]  set_month,
    input  logic [7:0]  set_day,
    input  logic [7:0]  set_hour,
    input  logic [7:0]  set_minute,
    input  logic [7:0]  set_sec,
    input  logic [3:0]  set_week,
    output logic [15:0] year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  sec,
    output logic [3:0]  week,
    output logic        sec_tick,
    output logic        load_err
);

    localparam int              c_PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(CLK_HZ - 1);

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------
    function automatic logic [3:0] f_inc_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Two-digit increment; 99 wraps to 00 (callers handle the carry-out).
    function automatic logic [7:0] f_inc_pair(input logic [7:0] p);
        return {((p[3:0] == 4'd9) ? f_inc_digit(p[7:4]) : p[7:4]),
                f_inc_digit(p[3:0])};
    endfunction

    function automatic logic [15:0] f_inc_year(input logic [15:0] y);
        return {((y[7:0] == 8'h99) ? f_inc_pair(y[15:8]) : y[15:8]),
                f_inc_pair(y[7:0])};
    endfunction

    // Divisibility by 4 read directly off the BCD digits: 10*t+u is a
    // multiple of 4 iff u is 0/4/8 with t even, or 2/6 with t odd.
    function automatic logic f_div4(input logic [7:0] p);
        logic [3:0] u;
        u = p[3:0];
        if (!p[4])
            return (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
        else
            return (u == 4'd2) || (u == 4'd6);
    endfunction

    // Century years (yy == 00) are leap only when cc is a multiple of 4.
    function automatic logic f_is_leap(input logic [15:0] y);
        return (y[7:0] != 8'h00) ? f_div4(y[7:0]) : f_div4(y[15:8]);
    endfunction

    // Days in month, returned as BCD so it compares directly with day.
    function automatic logic [7:0] f_dim(input logic [7:0] m, input logic [15:0] y);
        case (m)
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            8'h02:                      return f_is_leap(y) ? 8'h29 : 8'h28;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic logic f_digits_ok(input logic [7:0] p);
        return (p[7:4] <= 4'd9) && (p[3:0] <= 4'd9);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_presc;
    logic [15:0]     r_year;
    logic [7:0]      r_month, r_day, r_hour, r_minute, r_sec;
    logic [3:0]      r_week;
    logic            r_sec_tick, r_load_err;

    // ------------------------------------------------------------------
    // Load validation (BCD comparisons are numeric once digits are legal)
    // ------------------------------------------------------------------
    logic [7:0] w_set_dim;
    logic       w_load_valid;

    assign w_set_dim    = f_dim(set_month, set_year);
    assign w_load_valid = f_digits_ok(set_year[15:8]) && f_digits_ok(set_year[7:0]) &&
                          f_digits_ok(set_month) && f_digits_ok(set_day) &&
                          f_digits_ok(set_hour) && f_digits_ok(set_minute) &&
                          f_digits_ok(set_sec) &&
                          (set_month >= 8'h01) && (set_month <= 8'h12) &&
                          (set_day >= 8'h01) && (set_day <= w_set_dim) &&
                          (set_hour <= 8'h23) && (set_minute <= 8'h59) &&
                          (set_sec <= 8'h59) && (set_week <= 4'd6);

    // ------------------------------------------------------------------
    // Carry chain: each field advances only when every lower field wraps
    // ------------------------------------------------------------------
    logic        w_wrap;
    logic [7:0]  w_dim;
    logic        w_sec_wrap, w_min_wrap, w_hour_wrap, w_day_wrap, w_month_wrap;
    logic [15:0] w_year_nx;
    logic [7:0]  w_month_nx, w_day_nx, w_hour_nx, w_minute_nx, w_sec_nx;
    logic [3:0]  w_week_nx;

    assign w_wrap       = run_en && (r_presc == c_PRESC_MAX);
    assign w_dim        = f_dim(r_month, r_year);
    assign w_sec_wrap   = (r_sec == 8'h59);
    assign w_min_wrap   = w_sec_wrap && (r_minute == 8'h59);
    assign w_hour_wrap  = w_min_wrap && (r_hour == 8'h23);
    assign w_day_wrap   = w_hour_wrap && (r_day == w_dim);
    assign w_month_wrap = w_day_wrap && (r_month == 8'h12);

    assign w_sec_nx    = w_sec_wrap ? 8'h00 : f_inc_pair(r_sec);
    assign w_minute_nx = !w_sec_wrap ? r_minute :
                         ((r_minute == 8'h59) ? 8'h00 : f_inc_pair(r_minute));
    assign w_hour_nx   = !w_min_wrap ? r_hour :
                         ((r_hour == 8'h23) ? 8'h00 : f_inc_pair(r_hour));
    assign w_week_nx   = !w_hour_wrap ? r_week :
                         ((r_week == 4'd6) ? 4'd0 : r_week + 4'd1);
    assign w_day_nx    = !w_hour_wrap ? r_day :
                         ((r_day == w_dim) ? 8'h01 : f_inc_pair(r_day));
    assign w_month_nx  = !w_day_wrap ? r_month :
                         ((r_month == 8'h12) ? 8'h01 : f_inc_pair(r_month));
    assign w_year_nx   = w_month_wrap ? f_inc_year(r_year) : r_year;

    // ------------------------------------------------------------------
    // Registers: rst > valid load > tick. An invalid load leaves the
    // prescaler and any coincident tick untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc    <= '0;
            r_year     <= 16'h2023;
            r_month    <= 8'h01;
            r_day      <= 8'h01;
            r_hour     <= 8'h00;
            r_minute   <= 8'h00;
            r_sec      <= 8'h00;
            r_week     <= 4'd0;
            r_sec_tick <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            r_load_err <= 1'b0;
            if (load && w_load_valid) begin
                r_presc  <= '0;
                r_year   <= set_year;
                r_month  <= set_month;
                r_day    <= set_day;
                r_hour   <= set_hour;
                r_minute <= set_minute;
                r_sec    <= set_sec;
                r_week   <= set_week;
            end else begin
                if (load)
                    r_load_err <= 1'b1;
                if (run_en)
                    r_presc <= w_wrap ? '0 : r_presc + c_PW'(1);
                if (w_wrap) begin
                    r_year     <= w_year_nx;
                    r_month    <= w_month_nx;
                    r_day      <= w_day_nx;
                    r_hour     <= w_hour_nx;
                    r_minute   <= w_minute_nx;
                    r_sec      <= w_sec_nx;
                    r_week     <= w_week_nx;
                    r_sec_tick <= 1'b1;
                end
            end
        end
    end

    assign year     = r_year;
    assign month    = r_month;
    assign day      = r_day;
    assign hour     = r_hour;
    assign minute   = r_minute;
    assign sec      = r_sec;
    assign week     = r_week;
    assign sec_tick = r_sec_tick;
    assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_rtc_calendar_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_calendar_counter
// Description : Self-checking bench for rtc_calendar_counter (CLK_HZ = 4).
//               Directed vector table for calendar corners and rejected
//               loads, hand-written sequences for timing corners, and a
//               randomized run against an integer-arithmetic calendar model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_calendar_counter;

    localparam int CLK_HZ = 4;

    logic        clk = 1'b0;
    logic        rst, run_en, load;
    logic [15:0] set_year;
    logic [7:0]  set_month, set_day, set_hour, set_minute, set_sec;
    logic [3:0]  set_week;
    logic [15:0] year;
    logic [7:0]  month, day, hour, minute, sec;
    logic [3:0]  week;
    logic        sec_tick, load_err;

    rtc_calendar_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .load(load),
        .set_year(set_year), .set_month(set_month), .set_day(set_day),
        .set_hour(set_hour), .set_minute(set_minute), .set_sec(set_sec),
        .set_week(set_week),
        .year(year), .month(month), .day(day), .hour(hour),
        .minute(minute), .sec(sec), .week(week),
        .sec_tick(sec_tick), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model (plain integers) ----------------
    int m_year, m_month, m_day, m_hour, m_min, m_sec, m_week, m_presc;
    bit m_tick, m_err;

    function automatic bit is_leap(int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int dim_int(int m, int y);
        case (m)
            2:             return is_leap(y) ? 29 : 28;
            4, 6, 9, 11:   return 30;
            default:       return 31;
        endcase
    endfunction

    function automatic bit ok8(logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic int b2i(logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] i2b8(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] i2b16(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit load_valid();
        int yr, mo, d;
        if (!(ok8(set_year[15:8]) && ok8(set_year[7:0]) && ok8(set_month) && ok8(set_day) &&
              ok8(set_hour) && ok8(set_minute) && ok8(set_sec)))
            return 1'b0;
        if (set_week > 4'd6) return 1'b0;
        yr = b2i(set_year[15:8]) * 100 + b2i(set_year[7:0]);
        mo = b2i(set_month);
        d  = b2i(set_day);
        if (mo < 1 || mo > 12) return 1'b0;
        if (d < 1 || d > dim_int(mo, yr)) return 1'b0;
        if (b2i(set_hour) > 23 || b2i(set_minute) > 59 || b2i(set_sec) > 59) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_year = 2023; m_month = 1; m_day = 1; m_hour = 0; m_min = 0; m_sec = 0;
        m_week = 0; m_presc = 0; m_tick = 0; m_err = 0;
    endtask

    task automatic model_advance();
        m_sec++;
        if (m_sec == 60) begin
            m_sec = 0; m_min++;
            if (m_min == 60) begin
                m_min = 0; m_hour++;
                if (m_hour == 24) begin
                    m_hour = 0;
                    m_week = (m_week + 1) % 7;
                    m_day++;
                    if (m_day > dim_int(m_month, m_year)) begin
                        m_day = 1; m_month++;
                        if (m_month > 12) begin
                            m_month = 1;
                            m_year = (m_year + 1) % 10000;
                        end
                    end
                end
            end
        end
    endtask

    task automatic model_step();
        bit wrap;
        wrap   = run_en && (m_presc == CLK_HZ - 1);
        m_tick = 1'b0;
        m_err  = 1'b0;
        if (load && load_valid()) begin
            m_year  = b2i(set_year[15:8]) * 100 + b2i(set_year[7:0]);
            m_month = b2i(set_month); m_day = b2i(set_day); m_hour = b2i(set_hour);
            m_min   = b2i(set_minute); m_sec = b2i(set_sec); m_week = int'(set_week);
            m_presc = 0;
        end else begin
            if (load) m_err = 1'b1;
            if (run_en) m_presc = wrap ? 0 : m_presc + 1;
            if (wrap) begin
                model_advance();
                m_tick = 1'b1;
            end
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {2'b00, year, month, day, hour, minute, sec, week, sec_tick, load_err};
    endfunction

    function automatic logic [63:0] model_vec();
        return {2'b00, i2b16(m_year), i2b8(m_month), i2b8(m_day), i2b8(m_hour),
                i2b8(m_min), i2b8(m_sec), 4'(m_week), m_tick, m_err};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 ns later.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic set_fields(logic [15:0] y, logic [7:0] mo, logic [7:0] d, logic [7:0] h,
                              logic [7:0] mi, logic [7:0] s, logic [3:0] w);
        set_year = y; set_month = mo; set_day = d; set_hour = h;
        set_minute = mi; set_sec = s; set_week = w;
    endtask

    task automatic rand_load();
        int y, mo, d, h, mi, s, w, dm;
        y  = ($urandom % 3 == 0) ? (($urandom % 2 == 0) ? 9999 : 100 * int'($urandom_range(0, 99)))
                                 : int'($urandom_range(0, 9999));
        mo = int'($urandom_range(1, 12));
        dm = dim_int(mo, y);
        d  = ($urandom % 2 == 0) ? dm : int'($urandom_range(1, dm));
        h  = ($urandom % 2 == 0) ? 23 : int'($urandom_range(0, 23));
        mi = ($urandom % 2 == 0) ? 59 : int'($urandom_range(0, 59));
        s  = ($urandom % 2 == 0) ? int'($urandom_range(56, 59)) : int'($urandom_range(0, 59));
        w  = int'($urandom_range(0, 6));
        set_fields(i2b16(y), i2b8(mo), i2b8(d), i2b8(h), i2b8(mi), i2b8(s), 4'(w));
        if ($urandom % 4 == 0) begin
            case ($urandom % 5)
                0: set_day   = i2b8(dm + 1);
                1: set_sec   = 8'h5A;
                2: set_month = 8'h00;
                3: set_week  = 4'd7;
                default: set_hour = 8'h24;
            endcase
        end
    endtask

    typedef struct {
        logic [15:0] y;
        logic [7:0]  mo, d, h, mi, s;
        logic [3:0]  w;
        bit          err;
        logic [15:0] ey;
        logic [7:0]  emo, ed, eh, emi, es;
        logic [3:0]  ew;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int ticks, last_tick, n;
        bit got;

        tbl[0]  = '{16'h2024, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd3, 1'b0,
                    16'h2024, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 4'd4};
        tbl[1]  = '{16'h2023, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd3, 1'b0,
                    16'h2023, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 4'd4};
        tbl[2]  = '{16'h2100, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd1, 1'b0,
                    16'h2100, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 4'd2};
        tbl[3]  = '{16'h2000, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 4'd1, 1'b0,
                    16'h2000, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 4'd2};
        tbl[4]  = '{16'h9999, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 4'd5, 1'b0,
                    16'h0000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd6};
        tbl[5]  = '{16'h2023, 8'h04, 8'h30, 8'h23, 8'h59, 8'h59, 4'd6, 1'b0,
                    16'h2023, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0};
        tbl[6]  = '{16'h2023, 8'h04, 8'h31, 8'h10, 8'h00, 8'h00, 4'd0, 1'b1,
                    16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 4'd0};
        tbl[7]  = '{16'h2023, 8'h05, 8'h10, 8'h10, 8'h00, 8'h5A, 4'd0, 1'b1,
                    16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 4'd0};
        tbl[8]  = '{16'h2023, 8'h13, 8'h01, 8'h10, 8'h00, 8'h00, 4'd0, 1'b1,
                    16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 4'd0};
        tbl[9]  = '{16'h2023, 8'h02, 8'h29, 8'h10, 8'h00, 8'h00, 4'd0, 1'b1,
                    16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 4'd0};
        tbl[10] = '{16'h2023, 8'h06, 8'h01, 8'h10, 8'h00, 8'h00, 4'd7, 1'b1,
                    16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 4'd0};

        rst = 1'b1; run_en = 1'b0; load = 1'b0;
        set_fields(16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 4'd0);
        model_reset();
        cycle(); cycle();
        check("reset_state", 64'(dut_vec()),
              {2'b00, 16'h2023, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0});

        // Free run from reset: tick every CLK_HZ cycles, BCD units carry.
        rst = 1'b0; run_en = 1'b1;
        ticks = 0; last_tick = 0; got = 1'b0;
        for (int c = 1; c <= 60 && !got; c++) begin
            cycle();
            if (sec_tick) begin
                ticks++;
                check("tick_spacing", 64'(c - last_tick), 64'(CLK_HZ));
                last_tick = c;
                if (ticks == 9)  check("sec_09", 64'(sec), 64'(8'h09));
                if (ticks == 10) begin
                    check("sec_10", 64'(sec), 64'(8'h10));
                    got = 1'b1;
                end
            end
        end
        if (!got) check("free_run_timeout", 64'(ticks), 64'(10));

        // Vector table: valid loads followed by one tick, rejected loads.
        for (int i = 0; i < 11; i++) begin
            run_en = tbl[i].err ? 1'b0 : 1'b1;
            set_fields(tbl[i].y, tbl[i].mo, tbl[i].d, tbl[i].h, tbl[i].mi, tbl[i].s, tbl[i].w);
            load = 1'b1;
            cycle();
            load = 1'b0;
            if (tbl[i].err) begin
                check("load_err_pulse", 64'(load_err), 64'(1));
                cycle();
                check("load_err_clear", 64'(load_err), 64'(0));
            end else begin
                check("load_value", 64'({year, month, day, hour, minute, sec, week, sec_tick}),
                      64'({tbl[i].y, tbl[i].mo, tbl[i].d, tbl[i].h, tbl[i].mi, tbl[i].s,
                           tbl[i].w, 1'b0}));
                got = 1'b0;
                for (int c = 0; c < 8 && !got; c++) begin
                    cycle();
                    if (sec_tick) got = 1'b1;
                end
                if (!got) check("vec_tick_timeout", 64'(0), 64'(1));
                check("vec_rollover", 64'({year, month, day, hour, minute, sec, week}),
                      64'({tbl[i].ey, tbl[i].emo, tbl[i].ed, tbl[i].eh, tbl[i].emi,
                           tbl[i].es, tbl[i].ew}));
            end
        end

        // Valid load on the wrap cycle discards the tick and restarts the prescaler.
        run_en = 1'b1;
        for (int c = 0; c < 8 && m_presc != CLK_HZ - 1; c++) cycle();
        set_fields(16'h2023, 8'h06, 8'h15, 8'h12, 8'h30, 8'h45, 4'd4);
        load = 1'b1;
        cycle();
        load = 1'b0;
        check("wrap_load_no_tick", 64'({sec_tick, sec}), 64'({1'b0, 8'h45}));
        n = 0; got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            cycle();
            n++;
            if (sec_tick) got = 1'b1;
        end
        check("tick_after_load", 64'(n), 64'(4));
        check("sec_after_load", 64'(sec), 64'(8'h46));

        // Hold with run_en low, then resume.
        run_en = 1'b0;
        repeat (10) cycle();
        check("hold", 64'({sec_tick, minute, sec}), 64'({1'b0, 8'h30, 8'h46}));
        run_en = 1'b1;
        cycle(); cycle();

        // Asynchronous reset mid-cycle takes effect before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 64'({year, month, day, hour, minute, sec, week}),
              64'({16'h2023, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'd0}));
        model_reset();
        cycle();
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            run_en = ($urandom % 6) != 0;
            load   = ($urandom % 10) == 0;
            if (load) rand_load();
            cycle();
        end
        load = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
